// File: rtl/matrix_row_encoder.sv
// Row matrix encoder: gathers p11..p14 serially, emits p11..p14 and z11..z13 with optional single-byte fault injection.
// Latency: codeword valid one cycle after the 4th byte edge; in_ready stays low until the held codeword is accepted.
module matrix_row_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        inj_en,
    input  logic [1:0]  inj_sel,
    input  logic [7:0]  inj_mask,
    input  logic        out_ready,
    output logic        out_valid,
    output logic        err,
    output logic [7:0]  p11,
    output logic [7:0]  p12,
    output logic [7:0]  p13,
    output logic [7:0]  p14,
    output logic [7:0]  z11,
    output logic [7:0]  z12,
    output logic [7:0]  z13,
    output logic [15:0] rows_out
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ENCODE  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0][7:0] p;
        logic [2:0][7:0] z;
    } cw_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][7:0] data_q, data_d;
    cw_t             cw_q, cw_d;
    logic [15:0]     rows_q, rows_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            data_q  <= '0;
            cw_q    <= '0;
            rows_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            cw_q    <= cw_d;
            rows_q  <= rows_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cw_d    = cw_q;
        rows_d  = rows_q;
        case (state_q)
            COLLECT: begin
                if (in_valid) begin
                    data_d[idx_q] = in_data;
                    idx_d         = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = ENCODE;
                    end
                end
            end
            ENCODE: begin
                // Check bytes always come from the clean data so injected faults stay correctable.
                cw_d.z[0] = data_q[0] ^ data_q[1] ^ data_q[2];
                cw_d.z[1] = data_q[0] ^ data_q[1] ^ data_q[3];
                cw_d.z[2] = data_q[0] ^ data_q[2] ^ data_q[3];
                cw_d.p    = data_q;
                if (inj_en) begin
                    cw_d.p[inj_sel] = data_q[inj_sel] ^ inj_mask;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    rows_d  = rows_q + 16'd1;
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = 2'd0;
            end
        endcase
    end

    assign in_ready  = (state_q == COLLECT) & ~rst;
    assign out_valid = (state_q == HOLD);
    assign err       = out_valid;
    assign p11       = cw_q.p[0];
    assign p12       = cw_q.p[1];
    assign p13       = cw_q.p[2];
    assign p14       = cw_q.p[3];
    assign z11       = cw_q.z[0];
    assign z12       = cw_q.z[1];
    assign z13       = cw_q.z[2];
    assign rows_out  = rows_q;

endmodule

// File: tb/tb_matrix_row_encoder.sv
// Bench for matrix_row_encoder: queue-based reference model checked every cycle, plus directed literal checks.
module tb_matrix_row_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        inj_en;
    logic [1:0]  inj_sel;
    logic [7:0]  inj_mask;
    logic        out_ready;
    logic        out_valid;
    logic        err;
    logic [7:0]  p11, p12, p13, p14;
    logic [7:0]  z11, z12, z13;
    logic [15:0] rows_out;

    int total = 0;
    int bad   = 0;

    matrix_row_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .inj_en(inj_en), .inj_sel(inj_sel), .inj_mask(inj_mask),
        .out_ready(out_ready), .out_valid(out_valid), .err(err),
        .p11(p11), .p12(p12), .p13(p13), .p14(p14),
        .z11(z11), .z12(z12), .z13(z13),
        .rows_out(rows_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: bytes collected so far, an encode pending, a codeword pending.
    logic [7:0]  m_bytes[$];
    bit          m_enc  = 1'b0;
    bit          m_hold = 1'b0;
    logic [7:0]  m_p[4] = '{default: 8'h00};
    logic [7:0]  m_z[3] = '{default: 8'h00};
    logic [15:0] m_rows = 16'h0000;
    bit          preload_req = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_bytes.delete();
                m_enc  = 1'b0;
                m_hold = 1'b0;
                for (int i = 0; i < 4; i++) m_p[i] = 8'h00;
                for (int i = 0; i < 3; i++) m_z[i] = 8'h00;
                m_rows = 16'h0000;
            end else begin
                if (preload_req) m_rows = 16'hFFFF;
                if (m_hold) begin
                    if (out_ready) begin
                        m_hold = 1'b0;
                        m_rows = m_rows + 16'd1;
                    end
                end else if (m_enc) begin
                    m_z[0] = m_bytes[0] ^ m_bytes[1] ^ m_bytes[2];
                    m_z[1] = m_bytes[0] ^ m_bytes[1] ^ m_bytes[3];
                    m_z[2] = m_bytes[0] ^ m_bytes[2] ^ m_bytes[3];
                    for (int i = 0; i < 4; i++) m_p[i] = m_bytes[i];
                    if (inj_en) m_p[inj_sel] = m_p[inj_sel] ^ inj_mask;
                    m_bytes.delete();
                    m_enc  = 1'b0;
                    m_hold = 1'b1;
                end else if (in_valid) begin
                    m_bytes.push_back(in_data);
                    if (m_bytes.size() == 4) m_enc = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready",  {31'd0, in_ready},  {31'd0, (!rst && !m_enc && !m_hold)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
            chk("err",       {31'd0, err},       {31'd0, m_hold});
            chk("p_bytes",   {p11, p12, p13, p14}, {m_p[0], m_p[1], m_p[2], m_p[3]});
            chk("z_bytes",   {8'd0, z11, z12, z13}, {8'd0, m_z[0], m_z[1], m_z[2]});
            chk("rows_out",  {16'd0, rows_out}, {16'd0, m_rows});
        end
    end

    task automatic push(input logic [7:0] b);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            @(negedge clk);
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: byte %h not accepted within 20 cycles", b);
        end
        in_valid = 1'b0;
    endtask

    task automatic push_row(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        push(a);
        push(b);
        push(c);
        push(d);
    endtask

    bit         gap_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] gap_dat[4] = '{8'hA5, 8'h5A, 8'hFF, 8'h00};
    logic [7:0] s1, s3;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        inj_en = 1'b0; inj_sel = 2'd0; inj_mask = 8'h00; out_ready = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rows", {16'd0, rows_out}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Clean row, back-to-back, out_ready high.
        out_ready = 1'b1;
        push_row(8'h11, 8'h22, 8'h44, 8'h88);
        chk("clean_encode_not_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("clean_valid", {31'd0, out_valid}, 32'd1);
        chk("clean_p", {p11, p12, p13, p14}, 32'h11224488);
        chk("clean_z", {8'd0, z11, z12, z13}, 32'h0077BBDD);
        chk("model_clean_z", {8'd0, m_z[0], m_z[1], m_z[2]}, 32'h0077BBDD);
        @(negedge clk);
        chk("clean_valid_drop", {31'd0, out_valid}, 32'd0);
        chk("clean_rows", {16'd0, rows_out}, 32'd1);

        // Injection on p12.
        inj_en = 1'b1; inj_sel = 2'd1; inj_mask = 8'h01;
        push_row(8'h11, 8'h22, 8'h44, 8'h88);
        @(negedge clk);
        chk("inj_p", {p11, p12, p13, p14}, 32'h11234488);
        chk("inj_z", {8'd0, z11, z12, z13}, 32'h0077BBDD);
        chk("model_inj_p12", {24'd0, m_p[1]}, 32'h23);
        s1 = p11 ^ p12 ^ p13 ^ z11;
        s3 = p11 ^ p13 ^ p14 ^ z13;
        chk("inj_syndrome_s3", {24'd0, s3}, 32'h0);
        chk("inj_corrected_p12", {24'd0, p12 ^ s1}, 32'h22);
        inj_en = 1'b0; inj_mask = 8'h00; inj_sel = 2'd0;
        @(negedge clk);

        // Backpressure: held codeword, bytes offered during HOLD must be ignored.
        out_ready = 1'b0;
        push_row(8'h01, 8'h02, 8'h03, 8'h04);
        in_valid = 1'b1; in_data = 8'hEE;
        repeat (6) @(negedge clk);
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_p", {p11, p12, p13, p14}, 32'h01020304);
        out_ready = 1'b1;
        push_row(8'h99, 8'h98, 8'h97, 8'h96);
        @(negedge clk);
        chk("bp_next_p11", {24'd0, p11}, 32'h99);
        @(negedge clk);

        // Gapped input.
        begin
            int k;
            k = 0;
            for (int i = 0; i < 7; i++) begin
                in_valid = gap_pat[i];
                if (gap_pat[i]) begin
                    in_data = gap_dat[k];
                    k++;
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_p", {p11, p12, p13, p14}, 32'hA55AFF00);
        chk("gap_z", {8'd0, z11, z12, z13}, 32'h0000FF5A);
        @(negedge clk);

        // Reset mid-row discards the partial bytes.
        push(8'h01);
        push(8'h02);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_p", {p11, p12, p13, p14}, 32'h0);
        chk("midrst_rows", {16'd0, rows_out}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        push_row(8'h10, 8'h20, 8'h30, 8'h40);
        @(negedge clk);
        chk("midrst_row_p", {p11, p12, p13, p14}, 32'h10203040);
        chk("midrst_row_z", {8'd0, z11, z12, z13}, 32'h00007060);
        @(negedge clk);

        // Reset while holding a codeword.
        out_ready = 1'b0;
        push_row(8'h0F, 8'hF0, 8'h3C, 8'hC3);
        @(negedge clk);
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("holdrst_valid", {31'd0, out_valid}, 32'd0);
        chk("holdrst_err", {31'd0, err}, 32'd0);
        chk("holdrst_z", {8'd0, z11, z12, z13}, 32'h0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Counter wrap: preload 0xFFFF, then one handoff.
        #2 force dut.rows_q = 16'hFFFF;
        preload_req = 1'b1;
        #1 release dut.rows_q;
        @(negedge clk);
        preload_req = 1'b0;
        chk("wrap_preload", {16'd0, rows_out}, 32'h0000FFFF);
        push_row(8'h12, 8'h34, 8'h56, 8'h78);
        repeat (2) @(negedge clk);
        chk("wrap_rows", {16'd0, rows_out}, 32'h0);
        chk("model_wrap_rows", {16'd0, m_rows}, 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 8'($urandom);
            inj_en    = ($urandom_range(0, 9) < 3);
            inj_sel   = 2'($urandom);
            inj_mask  = 8'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
